// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and fills the IF/ID register.
// Optional out-of-range fetch trap enabled by defining FETCH_BOUNDS_CHECK_EN.
module fetch_stage #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int unsigned MEM_BYTES = 1024,
   parameter logic [31:0] HALT_WORD = 32'h14000000,
   parameter logic [31:0] NOP_WORD  = 32'hD503201F
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [63:0] redirect_target,
   output logic [63:0] ifid_pc,
   output logic [31:0] ifid_instr,
   output logic        ifid_valid,
   output logic        halted,
   output logic        fault
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [63:0] pc_reg, pc_next;
   logic [63:0] ifid_pc_reg, ifid_pc_next;
   logic [31:0] ifid_instr_reg, ifid_instr_next;
   logic        ifid_valid_reg, ifid_valid_next;
   logic [63:0] pc_inc;
   logic [63:0] target_aligned;
   logic        out_of_bounds;
   logic        fault_set;

   assign pc_inc         = pc_reg + 64'd4;
   assign target_aligned = redirect_target & ~64'h3;

`ifdef FETCH_BOUNDS_CHECK_EN
   localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);
   logic        fault_reg;
   logic [64:0] pc_last_byte;

   // Widened so a PC near the top of the address space cannot wrap past the check.
   assign pc_last_byte  = {1'b0, pc_reg} + 65'd3;
   assign out_of_bounds = (pc_last_byte >= MEM_LIMIT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fault_reg <= 1'b0;
      end else if (fault_set) begin
         fault_reg <= 1'b1;
      end
   end

   assign fault = fault_reg;
`else
   assign out_of_bounds = 1'b0;
   assign fault         = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= BOOT;
         pc_reg         <= RESET_PC;
         ifid_pc_reg    <= 64'h0;
         ifid_instr_reg <= NOP_WORD;
         ifid_valid_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         pc_reg         <= pc_next;
         ifid_pc_reg    <= ifid_pc_next;
         ifid_instr_reg <= ifid_instr_next;
         ifid_valid_reg <= ifid_valid_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      pc_next         = pc_reg;
      ifid_pc_next    = ifid_pc_reg;
      ifid_instr_next = ifid_instr_reg;
      ifid_valid_next = ifid_valid_reg;
      fault_set       = 1'b0;

      case (state_reg)
         BOOT: begin
            ifid_valid_next = 1'b0;
            state_next      = RUN;
         end
         RUN: begin
            if (redirect) begin
               // Whatever is in IF/ID came from the wrong path.
               pc_next         = target_aligned;
               ifid_valid_next = 1'b0;
            end else if (out_of_bounds) begin
               ifid_valid_next = 1'b0;
               fault_set       = 1'b1;
               state_next      = HALT;
            end else if (stall && flush) begin
               ifid_valid_next = 1'b0;
            end else if (stall) begin
               ifid_valid_next = ifid_valid_reg;
            end else if (flush) begin
               ifid_valid_next = 1'b0;
               pc_next         = pc_inc;
            end else begin
               ifid_pc_next    = pc_reg;
               ifid_instr_next = imem_instr;
               ifid_valid_next = 1'b1;
               // Branch-to-self is issued once, then fetch parks on it.
               if (imem_instr == HALT_WORD) begin
                  state_next = HALT;
               end else begin
                  pc_next = pc_inc;
               end
            end
         end
         HALT: begin
            ifid_valid_next = 1'b0;
            if (redirect) begin
               pc_next    = target_aligned;
               state_next = RUN;
            end
         end
         default: begin
            state_next      = BOOT;
            ifid_valid_next = 1'b0;
         end
      endcase
   end

   assign imem_addr  = pc_reg;
   assign ifid_pc    = ifid_pc_reg;
   assign ifid_instr = ifid_instr_reg;
   assign ifid_valid = ifid_valid_reg;
   assign halted     = (state_reg == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed sequences, a vector table and
// a randomized run against a rule-level reference model.
module tb_fetch_stage;

   localparam logic [31:0] HALT_W = 32'h14000000;
   localparam logic [31:0] NOP_W  = 32'hD503201F;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        stall, flush, redirect;
   logic [63:0] redirect_target;
   logic [63:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        ifid_valid;
   logic        halted;
   logic        fault;

   int checks = 0;
   int errors = 0;

   logic [31:0] rom [256];

   fetch_stage dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .imem_addr       (imem_addr),
      .imem_instr      (imem_instr),
      .stall           (stall),
      .flush           (flush),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .ifid_pc         (ifid_pc),
      .ifid_instr      (ifid_instr),
      .ifid_valid      (ifid_valid),
      .halted          (halted),
      .fault           (fault)
   );

   always #5 clk = ~clk;

   // Combinational ROM; out-of-range addresses return a recognisable non-halt word.
   always_comb begin
      if (imem_addr < 64'd1024) imem_instr = rom[imem_addr[9:2]];
      else                      imem_instr = imem_addr[31:0] | 32'h1;
   end

   function automatic logic [31:0] rom_word(input logic [63:0] a);
      if (a < 64'd1024) return rom[a[9:2]];
      return a[31:0] | 32'h1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic f, input logic r, input logic [63:0] t);
      stall = s; flush = f; redirect = r; redirect_target = t;
   endtask

   typedef struct {
      logic        stall;
      logic        flush;
      logic        redirect;
      logic [63:0] target;
      logic [63:0] exp_addr;
      logic        exp_valid;
      logic        chk_pc;
      logic [63:0] exp_ipc;
   } vec_t;

   vec_t vecs[6];

   // Reference model state: mode 0=boot, 1=run, 2=halt.
   int          m_mode;
   logic [63:0] m_pc, m_ipc;
   logic [31:0] m_instr;
   logic        m_valid, m_fault;

   task automatic model_edge(input logic s, input logic f, input logic r, input logic [63:0] t);
      logic [31:0] w;
      logic        oob;
`ifdef FETCH_BOUNDS_CHECK_EN
      oob = ({1'b0, m_pc} + 65'd3) >= 65'd1024;
`else
      oob = 1'b0;
`endif
      if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 2) begin
         m_valid = 1'b0;
         if (r) begin
            m_pc   = {t[63:2], 2'b00};
            m_mode = 1;
         end
      end else if (r) begin
         m_pc    = {t[63:2], 2'b00};
         m_valid = 1'b0;
      end else if (oob) begin
         m_valid = 1'b0;
         m_fault = 1'b1;
         m_mode  = 2;
      end else if (s && f) begin
         m_valid = 1'b0;
      end else if (s) begin
         m_valid = m_valid;
      end else if (f) begin
         m_valid = 1'b0;
         m_pc    = m_pc + 64'd4;
      end else begin
         w       = rom_word(m_pc);
         m_ipc   = m_pc;
         m_instr = w;
         m_valid = 1'b1;
         if (w == HALT_W) m_mode = 2;
         else             m_pc = m_pc + 64'd4;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 32'hAA000000 + 32'(i);
      rom[0] = 32'h91000421;
      rom[1] = 32'h91000842;
      rom[4] = HALT_W;

      vecs[0] = '{1'b0, 1'b1, 1'b0, 64'h0,   64'h8,   1'b0, 1'b0, 64'h0};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 64'h0,   64'h8,   1'b0, 1'b0, 64'h0};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 64'h0,   64'hC,   1'b1, 1'b1, 64'h8};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 64'h0,   64'hC,   1'b1, 1'b1, 64'h8};
      vecs[4] = '{1'b0, 1'b1, 1'b1, 64'h101, 64'h100, 1'b0, 1'b0, 64'h0};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 64'h0,   64'h104, 1'b1, 1'b1, 64'h100};

      // Reset then run
      reset_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      repeat (2) step();
      check("rst_addr",  imem_addr,  64'h0);
      check("rst_valid", ifid_valid, 1'b0);
      check("rst_instr", ifid_instr, NOP_W);
      check("rst_ipc",   ifid_pc,    64'h0);
      check("rst_halt",  halted,     1'b0);
      check("rst_fault", fault,      1'b0);
      reset_n = 1'b1;
      step();
      check("boot_valid", ifid_valid, 1'b0);
      check("boot_addr",  imem_addr,  64'h0);
      step();
      check("run0_ipc",   ifid_pc,    64'h0);
      check("run0_instr", ifid_instr, 32'h91000421);
      check("run0_valid", ifid_valid, 1'b1);
      check("run0_addr",  imem_addr,  64'h4);
      step();
      check("run1_ipc",   ifid_pc,    64'h4);
      check("run1_instr", ifid_instr, 32'h91000842);
      check("run1_addr",  imem_addr,  64'h8);

      // Stall three cycles at 0x8
      drive(1'b1, 1'b0, 1'b0, 64'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_addr",  imem_addr,  64'h8);
         check("stall_ipc",   ifid_pc,    64'h4);
         check("stall_valid", ifid_valid, 1'b1);
      end
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      step();
      check("unstall_ipc", ifid_pc, 64'h8);

      // Redirect overrides stall and flush; low target bits dropped
      drive(1'b1, 1'b1, 1'b1, 64'h43);
      step();
      check("redir_addr",  imem_addr,  64'h40);
      check("redir_valid", ifid_valid, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      step();
      check("redir_ipc",   ifid_pc,    64'h40);
      check("redir_valid1", ifid_valid, 1'b1);

      // Halt on branch-to-self at 0x10
      drive(1'b0, 1'b0, 1'b1, 64'h8);
      step();
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      repeat (2) step();
      check("pre_halt_addr", imem_addr, 64'h10);
      step();
      check("halt_ipc",   ifid_pc,    64'h10);
      check("halt_instr", ifid_instr, HALT_W);
      check("halt_valid", ifid_valid, 1'b1);
      check("halt_addr",  imem_addr,  64'h10);
      drive(1'b1, 1'b1, 1'b0, 64'h0);
      repeat (2) begin
         step();
         check("halted",       halted,     1'b1);
         check("halted_valid", ifid_valid, 1'b0);
         check("halted_addr",  imem_addr,  64'h10);
      end
      drive(1'b0, 1'b0, 1'b1, 64'h0);
      step();
      check("resume_halted", halted,    1'b0);
      check("resume_addr",   imem_addr, 64'h0);
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      step();
      check("resume_ipc",   ifid_pc,    64'h0);
      check("resume_instr", ifid_instr, 32'h91000421);

      // Vector table: flush, stall+flush, stall, aliased redirect
      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].stall, vecs[i].flush, vecs[i].redirect, vecs[i].target);
         step();
         $display("vec %0d: s=%0b f=%0b r=%0b addr=%h valid=%0b", i,
                  vecs[i].stall, vecs[i].flush, vecs[i].redirect, imem_addr, ifid_valid);
         check("vec_addr",  imem_addr,  vecs[i].exp_addr);
         check("vec_valid", ifid_valid, vecs[i].exp_valid);
         if (vecs[i].chk_pc) check("vec_ipc", ifid_pc, vecs[i].exp_ipc);
      end

      // Top-of-ROM boundary
      drive(1'b0, 1'b0, 1'b1, 64'h3FF);
      step();
      check("bnd_addr", imem_addr, 64'h3FC);
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      step();
      check("bnd_ipc",   ifid_pc,    64'h3FC);
      check("bnd_instr", ifid_instr, 32'hAA0000FF);
      check("bnd_valid", ifid_valid, 1'b1);
      step();
`ifdef FETCH_BOUNDS_CHECK_EN
      check("oob_fault", fault,      1'b1);
      check("oob_halt",  halted,     1'b1);
      check("oob_valid", ifid_valid, 1'b0);
      check("oob_addr",  imem_addr,  64'h400);
`else
      check("oob_fault", fault,      1'b0);
      check("oob_ipc",   ifid_pc,    64'h400);
      check("oob_instr", ifid_instr, 32'h401);
      check("oob_valid", ifid_valid, 1'b1);
`endif
      drive(1'b0, 1'b0, 1'b1, 64'h10);
      step();
`ifdef FETCH_BOUNDS_CHECK_EN
      check("fault_sticky", fault, 1'b1);
`endif
      drive(1'b0, 1'b0, 0, 64'h0);
      step();
      check("halt2", halted, 1'b1);

      // Asynchronous reset between edges
      #3;
      reset_n = 1'b0;
      #1;
      check("arst_addr",  imem_addr,  64'h0);
      check("arst_valid", ifid_valid, 1'b0);
      check("arst_instr", ifid_instr, NOP_W);
      check("arst_ipc",   ifid_pc,    64'h0);
      check("arst_halt",  halted,     1'b0);
      check("arst_fault", fault,      1'b0);

      // Randomized run against the reference model
      for (int i = 0; i < 256; i++)
         rom[i] = ($urandom_range(0, 29) == 0) ? HALT_W : ($urandom | 32'h1);
      step();
      reset_n = 1'b1;
      m_mode = 0; m_pc = 64'h0; m_ipc = 64'h0; m_instr = NOP_W;
      m_valid = 1'b0; m_fault = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         logic        s, f, r;
         logic [63:0] t;
         int          sel;
         s   = ($urandom_range(0, 3) == 0);
         f   = ($urandom_range(0, 6) == 0);
         r   = ($urandom_range(0, 9) == 0);
         sel = $urandom_range(0, 9);
         if (sel < 7)       t = 64'($urandom_range(0, 1023));
         else if (sel < 9)  t = 64'h3F0 + 64'($urandom_range(0, 15));
         else               t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
         drive(s, f, r, t);
         model_edge(s, f, r, t);
         step();
         check("rnd_addr",  imem_addr,  m_pc);
         check("rnd_valid", ifid_valid, m_valid);
         check("rnd_halt",  halted,     (m_mode == 2));
         check("rnd_fault", fault,      m_fault);
         if (m_valid) begin
            check("rnd_ipc",   ifid_pc,    m_ipc);
            check("rnd_instr", ifid_instr, m_instr);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
